muldiv_unit: RTL and testbench

- Iterative multiply/divide unit that owns the HI/LO register pair for the MIPS core.
- The decoder raises start on mult/multu/div/divu, reads hi/lo on mfhi/mflo and writes them on mthi/mtlo.
- The unit is parametrised in operand width and in radix (iterations per cycle).
- It exposes busy so the datapath stalls mfhi/mflo and any new mul/div until the result lands.

---
 rtl/muldiv_pkg.sv | 16 +
 rtl/muldiv_step.sv | 34 +++
 rtl/muldiv_unit.sv | 199 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// op encodings and FSM states.
package muldiv_pkg;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_DIVU  = 2'b01;
  localparam logic [1:0] OP_MULT  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration on the {acc, opnd} pair: right-shifting
// shift-add multiply or left-shifting restoring divide.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] opnd_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] opnd_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] diff;
  logic             ge;

  always_comb begin
    sum  = {1'b0, acc_i} + (opnd_i[0] ? {1'b0, b_i} : '0);
    rem  = {acc_i, opnd_i[WIDTH-1]};
    // An explicit compare (not a borrow bit) keeps b=0 yielding all-ones/a.
    ge   = (rem >= {1'b0, b_i});
    diff = rem[WIDTH-1:0] - b_i;
    if (is_div) begin
      acc_o  = ge ? diff : rem[WIDTH-1:0];
      opnd_o = {opnd_i[WIDTH-2:0], ge};
    end else begin
      acc_o  = sum[WIDTH:1];
      opnd_o = {sum[0], opnd_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning the HI/LO pair.
// Optional signed mult/div for op 10/11 when MULDIV_SIGNED_EN is defined.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH           = 32,
  parameter int STEPS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int N     = WIDTH / STEPS_PER_CYCLE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             is_div_q, is_div_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             div_zero_q, div_zero_d;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rmd;
  logic               is_div_op;

  assign is_div_op = (op == OP_DIVU) || (op == OP_DIV);

`ifdef MULDIV_SIGNED_EN
  logic             signed_op, a_neg, b_neg;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] a_orig_q, a_orig_d;

  assign signed_op = (op == OP_MULT) || (op == OP_DIV);
  assign a_neg     = signed_op & a[WIDTH-1];
  assign b_neg     = signed_op & b[WIDTH-1];
  assign a_mag     = a_neg ? -a : a;
  assign b_mag     = b_neg ? -b : b;
`else
  assign a_mag = a;
  assign b_mag = b;
`endif

  logic [STEPS_PER_CYCLE:0][WIDTH-1:0] acc_chain;
  logic [STEPS_PER_CYCLE:0][WIDTH-1:0] opnd_chain;

  assign acc_chain[0]  = acc_q;
  assign opnd_chain[0] = opnd_q;

  generate
    for (genvar gi = 0; gi < STEPS_PER_CYCLE; gi++) begin : g_step
      muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div (is_div_q),
        .acc_i  (acc_chain[gi]),
        .opnd_i (opnd_chain[gi]),
        .b_i    (b_q),
        .acc_o  (acc_chain[gi+1]),
        .opnd_o (opnd_chain[gi+1])
      );
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    b_d        = b_q;
    is_div_d   = is_div_q;
    dz_d       = dz_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    div_zero_d = 1'b0;
    prod       = {acc_q, opnd_q};
    quo        = opnd_q;
    rmd        = acc_q;
`ifdef MULDIV_SIGNED_EN
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    a_orig_d   = a_orig_q;
    if (neg_res_q) begin
      prod = -prod;
      quo  = -quo;
    end
    if (neg_rem_q) rmd = -rmd;
`endif

    case (state_q)
      IDLE: begin
        if (wr_hi) hi_d = wr_data;
        if (wr_lo) lo_d = wr_data;
        if (start) begin
          state_d  = CALC;
          cnt_d    = CNT_W'(N - 1);
          acc_d    = '0;
          opnd_d   = a_mag;
          b_d      = b_mag;
          is_div_d = is_div_op;
          dz_d     = (b == '0);
`ifdef MULDIV_SIGNED_EN
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          a_orig_d  = a;
`endif
        end
      end
      CALC: begin
        acc_d  = acc_chain[STEPS_PER_CYCLE];
        opnd_d = opnd_chain[STEPS_PER_CYCLE];
        if (cnt_q == '0) state_d = FINISH;
        else             cnt_d   = cnt_q - 1'b1;
      end
      FINISH: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (is_div_q) begin
          div_zero_d = dz_q;
          hi_d       = rmd;
          lo_d       = quo;
`ifdef MULDIV_SIGNED_EN
          // Sign correction must not disturb the divide-by-zero result.
          if (dz_q) begin
            hi_d = a_orig_q;
            lo_d = '1;
          end
`endif
        end else begin
          {hi_d, lo_d} = prod;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      b_q        <= '0;
      is_div_q   <= 1'b0;
      dz_q       <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      a_orig_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      b_q        <= b_d;
      is_div_q   <= is_div_d;
      dz_q       <= dz_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
`ifdef MULDIV_SIGNED_EN
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      a_orig_q   <= a_orig_d;
`endif
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: one 1-step and one 4-step instance
// driven in parallel, checked against hand-computed results.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b, wr_data;
  logic        wr_hi, wr_lo;

  logic        busy1, done1, dz1, busy4, done4, dz4;
  logic [31:0] hi1, lo1, hi4, lo4;

  int n_checks = 0;
  int n_errors = 0;

  int          busy1_cnt, done1_cnt, dz1_cnt, busy4_cnt, done4_cnt, dz4_cnt;
  logic [31:0] hi1_cap, lo1_cap, hi4_cap, lo4_cap;
  logic        hold_bad;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32), .STEPS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
    .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data),
    .busy(busy1), .done(done1), .div_zero(dz1), .hi(hi1), .lo(lo1)
  );

  muldiv_unit #(.WIDTH(32), .STEPS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
    .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data),
    .busy(busy4), .done(done4), .div_zero(dz4), .hi(hi4), .lo(lo4)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Issue one operation and observe both instances for 40 cycles.
  // With poke set, a start and an mthi are attempted while busy.
  task automatic run_op(input logic [1:0] o, input logic [31:0] aa,
                        input logic [31:0] bb, input bit poke);
    logic [31:0] pre_hi1, pre_lo1, pre_hi4, pre_lo4;
    @(negedge clk);
    pre_hi1 = hi1; pre_lo1 = lo1; pre_hi4 = hi4; pre_lo4 = lo4;
    op = o; a = aa; b = bb; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy1_cnt = 0; done1_cnt = 0; dz1_cnt = 0;
    busy4_cnt = 0; done4_cnt = 0; dz4_cnt = 0;
    hold_bad = 1'b0;
    hi1_cap = '0; lo1_cap = '0; hi4_cap = '0; lo4_cap = '0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (busy1) begin
        busy1_cnt++;
        if (hi1 !== pre_hi1 || lo1 !== pre_lo1) hold_bad = 1'b1;
      end
      if (busy4) begin
        busy4_cnt++;
        if (hi4 !== pre_hi4 || lo4 !== pre_lo4) hold_bad = 1'b1;
      end
      if (done1) begin done1_cnt++; hi1_cap = hi1; lo1_cap = lo1; end
      if (done4) begin done4_cnt++; hi4_cap = hi4; lo4_cap = lo4; end
      if (dz1) dz1_cnt++;
      if (dz4) dz4_cnt++;
      if (poke && cyc == 3) begin
        start = 1'b1; op = 2'b00; a = 32'd1; b = 32'd1;
        wr_hi = 1'b1; wr_data = 32'h1234;
      end else begin
        start = 1'b0; wr_hi = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic check_op(input string tag, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input int exp_dz);
    check({tag, "_hi1"}, hi1_cap, exp_hi);
    check({tag, "_lo1"}, lo1_cap, exp_lo);
    check({tag, "_busy1"}, busy1_cnt, 33);
    check({tag, "_done1"}, done1_cnt, 1);
    check({tag, "_dz1"}, dz1_cnt, exp_dz);
    check({tag, "_hi4"}, hi4_cap, exp_hi);
    check({tag, "_lo4"}, lo4_cap, exp_lo);
    check({tag, "_busy4"}, busy4_cnt, 9);
    check({tag, "_done4"}, done4_cnt, 1);
    check({tag, "_dz4"}, dz4_cnt, exp_dz);
    check({tag, "_hold"}, hold_bad, 0);
    check({tag, "_idle"}, {busy1, busy4}, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    wr_hi = 1'b0; wr_lo = 1'b0; wr_data = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", {busy1, busy4}, 0);
    check("rst_done", {done1, done4, dz1, dz4}, 0);
    check("rst_hilo", {hi1, lo1}, 0);
    reset_n = 1'b1;

    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check_op("multu_max", 32'hFFFF_FFFE, 32'h0000_0001, 0);

    run_op(2'b01, 32'd100, 32'd7, 1'b0);
    check_op("divu_100_7", 32'd2, 32'd14, 0);

    // Same divide, with start and mthi attempted mid-operation.
    run_op(2'b01, 32'd100, 32'd7, 1'b1);
    check_op("divu_poke", 32'd2, 32'd14, 0);

    @(negedge clk);
    wr_hi = 1'b1; wr_data = 32'h1234;
    @(negedge clk);
    wr_hi = 1'b0;
    check("mthi_hi", hi1, 32'h1234);
    check("mthi_lo", lo1, 32'd14);
    wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 32'hABCD;
    @(negedge clk);
    wr_hi = 1'b0; wr_lo = 1'b0;
    check("mthilo", {hi1, lo1}, {32'hABCD, 32'hABCD});

    run_op(2'b01, 32'd5, 32'd0, 1'b0);
    check_op("divu_zero", 32'd5, 32'hFFFF_FFFF, 1);

`ifdef MULDIV_SIGNED_EN
    run_op(2'b10, 32'hFFFF_FFFD, 32'd4, 1'b0);
    check_op("mult_m3_4", 32'hFFFF_FFFF, 32'hFFFF_FFF4, 0);
    run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check_op("div_m7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check_op("div_minneg", 32'h0, 32'h8000_0000, 0);
    run_op(2'b11, 32'hFFFF_FFFB, 32'd0, 1'b0);
    check_op("div_zero_s", 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1);
`else
    run_op(2'b10, 32'hFFFF_FFFD, 32'd4, 1'b0);
    check_op("mult_m3_4", 32'h0000_0003, 32'hFFFF_FFF4, 0);
    run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check_op("div_m7_2", 32'd1, 32'h7FFF_FFFC, 0);
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check_op("div_minneg", 32'h8000_0000, 32'h0, 0);
`endif

    // mtlo in the same cycle as start: applied, then overwritten.
    @(negedge clk);
    wr_lo = 1'b1; wr_data = 32'hDEAD; start = 1'b1; op = 2'b00; a = 32'd6; b = 32'd7;
    @(negedge clk);
    wr_lo = 1'b0; start = 1'b0;
    check("wrstart_lo", lo1, 32'hDEAD);
    check("wrstart_busy", busy1, 1);
    begin
      int guard = 0;
      while (!done1 && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      check("wrstart_timeout", guard < 50, 1);
      check("wrstart_res", {hi1, lo1}, {32'd0, 32'd42});
    end

    // Asynchronous reset in the middle of a multiply.
    @(negedge clk);
    op = 2'b00; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("pre_rst_busy", busy1, 1);
    reset_n = 1'b0;
    #1;
    check("arst_busy", {busy1, busy4}, 0);
    check("arst_hilo1", {hi1, lo1}, 0);
    check("arst_hilo4", {hi4, lo4}, 0);
    @(negedge clk);
    reset_n = 1'b1;

    run_op(2'b00, 32'd6, 32'd7, 1'b0);
    check_op("multu_6_7", 32'd0, 32'd42, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
